// File: rtl/pipe_cunit.sv
// pipe_cunit: pipelined main control unit for a 5-stage MIPS datapath.
// Decodes the ID opcode, carries EX/M/WB control through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards (1-cycle stall), applies branch flush,
// flags illegal opcodes (sticky) and counts inserted bubbles (saturating).
// Ports: clk/rst (sync, active-high); op_in/id_rs/id_rt from ID; br_flush
// from MEM; pc_write/ifid_write (combinational, ~stall); ex_*, mem_*, wb_*
// registered control bundles; illegal; bubble_cnt.
module pipe_cunit #(
  parameter int AOP_W   = 3,
  parameter int EXT_OPS = 1,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_in,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             br_flush,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ex_regds,
  output logic             ex_alusrc,
  output logic [AOP_W-1:0] ex_aop,
  output logic             mem_branch,
  output logic             mem_bne,
  output logic             mem_jump,
  output logic             mem_mread,
  output logic             mem_mwrite,
  output logic             wb_mtor,
  output logic             wb_urw,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic             regds;
    logic             alusrc;
    logic [AOP_W-1:0] aop;
  } ex_t;

  typedef struct packed {
    logic branch;
    logic bne;
    logic jump;
    logic mread;
    logic mwrite;
  } m_t;

  typedef struct packed {
    logic mtor;
    logic urw;
  } wb_t;

  // ID decode results
  ex_t  dec_ex;
  m_t   dec_m;
  wb_t  dec_wb;
  logic dec_ill;
  logic dec_uses_rt;

  // Pipeline registers
  ex_t              idex_ex_q;
  m_t               idex_m_q;
  wb_t              idex_wb_q;
  logic [REG_W-1:0] ex_rt_q;
  m_t               exmem_m_q;
  wb_t              exmem_wb_q;
  wb_t              memwb_wb_q;
  logic             illegal_q;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] bubble_d;

  logic stall;

  always_comb begin
    dec_ex      = '0;
    dec_m       = '0;
    dec_wb      = '0;
    dec_ill     = 1'b0;
    dec_uses_rt = 1'b0;
    unique case (op_in)
      6'b000000: begin  // R-type
        dec_ex.regds = 1'b1; dec_ex.aop = AOP_W'(3'd2);
        dec_wb.mtor = 1'b1; dec_wb.urw = 1'b1; dec_uses_rt = 1'b1;
      end
      6'b001000: begin  // ADDI
        dec_ex.alusrc = 1'b1; dec_ex.aop = AOP_W'(3'd3);
        dec_wb.mtor = 1'b1; dec_wb.urw = 1'b1;
      end
      6'b001010: begin  // SLTI
        dec_ex.alusrc = 1'b1; dec_ex.aop = AOP_W'(3'd4);
        dec_wb.mtor = 1'b1; dec_wb.urw = 1'b1;
      end
      6'b001100: begin  // ANDI
        dec_ex.alusrc = 1'b1; dec_ex.aop = AOP_W'(3'd5);
        dec_wb.mtor = 1'b1; dec_wb.urw = 1'b1;
      end
      6'b001101: begin  // ORI
        dec_ex.alusrc = 1'b1; dec_ex.aop = AOP_W'(3'd6);
        dec_wb.mtor = 1'b1; dec_wb.urw = 1'b1;
      end
      6'b100011: begin  // LW
        dec_ex.alusrc = 1'b1; dec_ex.aop = AOP_W'(3'd3);
        dec_m.mread = 1'b1; dec_wb.urw = 1'b1;
      end
      6'b101011: begin  // SW
        dec_ex.alusrc = 1'b1; dec_ex.aop = AOP_W'(3'd3);
        dec_m.mwrite = 1'b1; dec_uses_rt = 1'b1;
      end
      6'b000100: begin  // BEQ
        dec_ex.aop = AOP_W'(3'd1); dec_m.branch = 1'b1; dec_uses_rt = 1'b1;
      end
      6'b000101: begin  // BNE
        if (EXT_OPS != 0) begin
          dec_ex.aop = AOP_W'(3'd1); dec_m.branch = 1'b1; dec_m.bne = 1'b1;
          dec_uses_rt = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      6'b000010: begin  // J
        if (EXT_OPS != 0) dec_m.jump = 1'b1;
        else              dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Load-use: the load in EX writes a register the ID instruction reads.
  // Flush and reset both override the stall so the PC is always free to load.
  assign stall = ~rst & ~br_flush & idex_m_q.mread & (ex_rt_q != '0) &
                 ((ex_rt_q == id_rs) | ((ex_rt_q == id_rt) & dec_uses_rt));

  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  assign bubble_d = ((stall | br_flush) && (bubble_q != {CNT_W{1'b1}}))
                    ? bubble_q + CNT_W'(1) : bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex_q  <= '0;
      idex_m_q   <= '0;
      idex_wb_q  <= '0;
      ex_rt_q    <= '0;
      exmem_m_q  <= '0;
      exmem_wb_q <= '0;
      memwb_wb_q <= '0;
      illegal_q  <= 1'b0;
      bubble_q   <= '0;
    end else begin
      if (dec_ill) illegal_q <= 1'b1;
      bubble_q   <= bubble_d;
      // MEM/WB always advances so a resolving branch still completes.
      memwb_wb_q <= exmem_wb_q;
      if (br_flush) begin
        exmem_m_q  <= '0;
        exmem_wb_q <= '0;
      end else begin
        exmem_m_q  <= idex_m_q;
        exmem_wb_q <= idex_wb_q;
      end
      if (br_flush || stall) begin
        idex_ex_q <= '0;
        idex_m_q  <= '0;
        idex_wb_q <= '0;
        ex_rt_q   <= '0;
      end else begin
        idex_ex_q <= dec_ex;
        idex_m_q  <= dec_m;
        idex_wb_q <= dec_wb;
        ex_rt_q   <= id_rt;
      end
    end
  end

  assign ex_regds   = idex_ex_q.regds;
  assign ex_alusrc  = idex_ex_q.alusrc;
  assign ex_aop     = idex_ex_q.aop;
  assign mem_branch = exmem_m_q.branch;
  assign mem_bne    = exmem_m_q.bne;
  assign mem_jump   = exmem_m_q.jump;
  assign mem_mread  = exmem_m_q.mread;
  assign mem_mwrite = exmem_m_q.mwrite;
  assign wb_mtor    = memwb_wb_q.mtor;
  assign wb_urw     = memwb_wb_q.urw;
  assign illegal    = illegal_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_cunit.sv
// Bench for pipe_cunit: three instances share stimulus (default params,
// EXT_OPS=0, CNT_W=2); directed scenario tasks plus a random run checked
// against a table-driven pipeline model.
module tb_pipe_cunit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br_flush = 1'b0;
  logic [5:0] op_in = 6'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // a_: default, e_: EXT_OPS=0, c_: CNT_W=2
  logic a_pcw, a_ifw, a_regds, a_alusrc, a_br, a_bne, a_j, a_mr, a_mw, a_mtor, a_urw, a_ill;
  logic e_pcw, e_ifw, e_regds, e_alusrc, e_br, e_bne, e_j, e_mr, e_mw, e_mtor, e_urw, e_ill;
  logic c_pcw, c_ifw, c_regds, c_alusrc, c_br, c_bne, c_j, c_mr, c_mw, c_mtor, c_urw, c_ill;
  logic [2:0]  a_aop, e_aop, c_aop;
  logic [15:0] a_cnt, e_cnt;
  logic [1:0]  c_cnt;

  pipe_cunit dut (
    .clk(clk), .rst(rst), .op_in(op_in), .id_rs(id_rs), .id_rt(id_rt), .br_flush(br_flush),
    .pc_write(a_pcw), .ifid_write(a_ifw), .ex_regds(a_regds), .ex_alusrc(a_alusrc),
    .ex_aop(a_aop), .mem_branch(a_br), .mem_bne(a_bne), .mem_jump(a_j), .mem_mread(a_mr),
    .mem_mwrite(a_mw), .wb_mtor(a_mtor), .wb_urw(a_urw), .illegal(a_ill), .bubble_cnt(a_cnt));

  pipe_cunit #(.EXT_OPS(0)) dut_e0 (
    .clk(clk), .rst(rst), .op_in(op_in), .id_rs(id_rs), .id_rt(id_rt), .br_flush(br_flush),
    .pc_write(e_pcw), .ifid_write(e_ifw), .ex_regds(e_regds), .ex_alusrc(e_alusrc),
    .ex_aop(e_aop), .mem_branch(e_br), .mem_bne(e_bne), .mem_jump(e_j), .mem_mread(e_mr),
    .mem_mwrite(e_mw), .wb_mtor(e_mtor), .wb_urw(e_urw), .illegal(e_ill), .bubble_cnt(e_cnt));

  pipe_cunit #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .op_in(op_in), .id_rs(id_rs), .id_rt(id_rt), .br_flush(br_flush),
    .pc_write(c_pcw), .ifid_write(c_ifw), .ex_regds(c_regds), .ex_alusrc(c_alusrc),
    .ex_aop(c_aop), .mem_branch(c_br), .mem_bne(c_bne), .mem_jump(c_j), .mem_mread(c_mr),
    .mem_mwrite(c_mw), .wb_mtor(c_mtor), .wb_urw(c_urw), .illegal(c_ill), .bubble_cnt(c_cnt));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic regds, branch, mread, mtor;
    logic [2:0] aop;
    logic mwrite, alusrc, urw, bne, jump;
  } ctl_t;

  ctl_t     m_ex, m_mem, m_wb;
  logic [4:0] m_rt;
  bit       m_ill, m_ill0;
  int       m_cnt;

  // Control table rows: RegDs,Branch,MRead,MtoR,AOp,MWrite,ALUsrc,Urw
  function automatic ctl_t ref_decode(input logic [5:0] op, input bit ext, output bit legal);
    logic [9:0] v;
    logic bn, jp;
    v = 10'b0; bn = 1'b0; jp = 1'b0; legal = 1'b1;
    case (op)
      6'b000000: v = 10'b1_0_0_1_010_0_0_1;
      6'b001000: v = 10'b0_0_0_1_011_0_1_1;
      6'b001010: v = 10'b0_0_0_1_100_0_1_1;
      6'b001100: v = 10'b0_0_0_1_101_0_1_1;
      6'b001101: v = 10'b0_0_0_1_110_0_1_1;
      6'b100011: v = 10'b0_0_1_0_011_0_1_1;
      6'b101011: v = 10'b0_0_0_0_011_1_1_0;
      6'b000100: v = 10'b0_1_0_0_001_0_0_0;
      6'b000101: if (ext) begin v = 10'b0_1_0_0_001_0_0_0; bn = 1'b1; end else legal = 1'b0;
      6'b000010: if (ext) jp = 1'b1; else legal = 1'b0;
      default:   legal = 1'b0;
    endcase
    return {v, bn, jp};
  endfunction

  function automatic bit ref_stall();
    bit uses_rt;
    uses_rt = (op_in == 6'b000000) || (op_in == 6'b101011) ||
              (op_in == 6'b000100) || (op_in == 6'b000101);
    return !rst && !br_flush && m_ex.mread && (m_rt != 0) &&
           ((m_rt == id_rs) || ((m_rt == id_rt) && uses_rt));
  endfunction

  always @(posedge clk) begin : model
    ctl_t d, d0;
    bit lg, lg0, st;
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_rt = 5'd0;
      m_ill = 1'b0; m_ill0 = 1'b0; m_cnt = 0;
    end else begin
      st = ref_stall();
      d  = ref_decode(op_in, 1'b1, lg);
      d0 = ref_decode(op_in, 1'b0, lg0);
      if (!lg)  m_ill  = 1'b1;
      if (!lg0) m_ill0 = 1'b1;
      if ((st || br_flush) && m_cnt < 65535) m_cnt++;
      m_wb  = m_mem;
      m_mem = br_flush ? '0 : m_ex;
      if (br_flush || st) begin m_ex = '0; m_rt = 5'd0; end
      else begin m_ex = d; m_rt = id_rt; end
    end
  end

  wire [15:0] a_vec = {a_regds, a_alusrc, a_aop, a_br, a_bne, a_j, a_mr, a_mw, a_mtor, a_urw, a_ill};
  wire [15:0] e_vec = {e_regds, e_alusrc, e_aop, e_br, e_bne, e_j, e_mr, e_mw, e_mtor, e_urw, e_ill};
  wire [15:0] c_vec = {c_regds, c_alusrc, c_aop, c_br, c_bne, c_j, c_mr, c_mw, c_mtor, c_urw, c_ill};
  wire [15:0] m_vec = {m_ex.regds, m_ex.alusrc, m_ex.aop, m_mem.branch, m_mem.bne, m_mem.jump,
                       m_mem.mread, m_mem.mwrite, m_wb.mtor, m_wb.urw, m_ill};
  wire [15:0] m_vec0 = {m_vec[15:1], m_ill0};

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl);
    op_in = op; id_rs = rs; id_rt = rt; br_flush = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(6'b000000, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; drive(OP_LW, 5'd1, 5'd1, 1'b0);
    #1;
    n_chk++;
    if ({a_pcw, a_ifw} !== 2'b11) begin
      n_err++; $display("FAIL reset_pcw: got %b expected 11", {a_pcw, a_ifw});
    end
    tick(); tick();
    n_chk++;
    if (a_vec !== 16'h0 || a_cnt !== 16'h0 || c_cnt !== 2'd0 || e_ill !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got vec=%h cnt=%0d c=%0d e_ill=%b expected 0",
                        a_vec, a_cnt, c_cnt, e_ill);
    end
    rst = 1'b0;
  endtask

  task automatic test_seq_flow();
    logic [5:0] ops [4];
    logic [9:0] rows[4];
    logic [9:0] v;
    ops[0] = OP_ADDI; rows[0] = 10'b0_0_0_1_011_0_1_1;
    ops[1] = OP_ORI;  rows[1] = 10'b0_0_0_1_110_0_1_1;
    ops[2] = OP_R;    rows[2] = 10'b1_0_0_1_010_0_0_1;
    ops[3] = OP_SW;   rows[3] = 10'b0_0_0_0_011_1_1_0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 4 ? ops[k] : OP_R, 5'd1, 5'd2, 1'b0);
      #1;
      n_chk++;
      if ({a_pcw, a_ifw, e_pcw, e_ifw, c_pcw, c_ifw} !== 6'b111111) begin
        n_err++; $display("FAIL seq_pcw[%0d]: got %b expected 111111", k,
                          {a_pcw, a_ifw, e_pcw, e_ifw, c_pcw, c_ifw});
      end
      tick();
      if (k < 4) begin
        v = rows[k];
        n_chk++;
        if ({a_regds, a_alusrc, a_aop} !== {v[9], v[1], v[5:3]}) begin
          n_err++; $display("FAIL seq_ex[%0d]: got %b expected %b", k,
                            {a_regds, a_alusrc, a_aop}, {v[9], v[1], v[5:3]});
        end
      end
      if (k >= 1 && k <= 4) begin
        v = rows[k-1];
        n_chk++;
        if ({a_br, a_mr, a_mw} !== {v[8], v[7], v[2]}) begin
          n_err++; $display("FAIL seq_mem[%0d]: got %b expected %b", k,
                            {a_br, a_mr, a_mw}, {v[8], v[7], v[2]});
        end
      end
      if (k >= 2) begin
        v = rows[k-2];
        n_chk++;
        if ({a_mtor, a_urw} !== {v[6], v[0]}) begin
          n_err++; $display("FAIL seq_wb[%0d]: got %b expected %b", k,
                            {a_mtor, a_urw}, {v[6], v[0]});
        end
      end
      n_chk++;
      if (e_vec !== m_vec0 || c_vec !== m_vec) begin
        n_err++; $display("FAIL seq_vec[%0d]: got e=%h c=%h expected e=%h c=%h", k,
                          e_vec, c_vec, m_vec0, m_vec);
      end
    end
    n_chk++;
    if (a_cnt !== 16'd0 || e_cnt !== 16'd0 || c_cnt !== 2'd0) begin
      n_err++; $display("FAIL seq_cnt: got %0d/%0d/%0d expected 0", a_cnt, e_cnt, c_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(OP_LW, 5'd1, 5'd5, 1'b0); tick();
    drive(OP_R, 5'd5, 5'd2, 1'b0); #1;
    n_chk++;
    if ({a_pcw, a_ifw} !== 2'b00) begin
      n_err++; $display("FAIL lu_stall: got %b expected 00", {a_pcw, a_ifw});
    end
    tick();
    n_chk++;
    if ({a_regds, a_alusrc, a_aop} !== 5'b0 || a_mr !== 1'b1) begin
      n_err++; $display("FAIL lu_bubble: got ex=%b mread=%b expected ex=00000 mread=1",
                        {a_regds, a_alusrc, a_aop}, a_mr);
    end
    n_chk++;
    if ({a_pcw, a_ifw} !== 2'b11) begin
      n_err++; $display("FAIL lu_release: got %b expected 11", {a_pcw, a_ifw});
    end
    tick();
    n_chk++;
    if (a_regds !== 1'b1 || a_aop !== 3'd2 || a_cnt !== 16'd1 || c_cnt !== 2'd1) begin
      n_err++; $display("FAIL lu_enter: got regds=%b aop=%0d cnt=%0d c=%0d expected 1 2 1 1",
                        a_regds, a_aop, a_cnt, c_cnt);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(OP_LW, 5'd1, 5'd0, 1'b0); tick();
    drive(OP_R, 5'd0, 5'd0, 1'b0); #1;
    n_chk++;
    if (a_pcw !== 1'b1) begin
      n_err++; $display("FAIL ns_rt0: got pc_write=%b expected 1", a_pcw);
    end
    tick();
    drive(OP_LW, 5'd1, 5'd7, 1'b0); tick();
    drive(OP_ADDI, 5'd3, 5'd7, 1'b0); #1;
    n_chk++;
    if (a_pcw !== 1'b1) begin
      n_err++; $display("FAIL ns_rtdest: got pc_write=%b expected 1", a_pcw);
    end
    tick();
    n_chk++;
    if (a_aop !== 3'd3 || a_alusrc !== 1'b1 || a_cnt !== 16'd0) begin
      n_err++; $display("FAIL ns_enter: got aop=%0d alusrc=%b cnt=%0d expected 3 1 0",
                        a_aop, a_alusrc, a_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(OP_ADDI, 5'd1, 5'd2, 1'b0); tick();
    drive(OP_BEQ, 5'd1, 5'd2, 1'b0);  tick();
    drive(OP_LW, 5'd1, 5'd4, 1'b0);   tick();
    // ID/EX: LW rt=4, EX/MEM: BEQ, MEM/WB: ADDI
    drive(OP_R, 5'd4, 5'd2, 1'b1); #1;
    n_chk++;
    if (a_pcw !== 1'b1 || a_ifw !== 1'b1 || a_br !== 1'b1) begin
      n_err++; $display("FAIL fl_suppress: got pcw=%b ifw=%b br=%b expected 1 1 1",
                        a_pcw, a_ifw, a_br);
    end
    tick();
    br_flush = 1'b0;
    n_chk++;
    if ({a_regds, a_alusrc, a_aop, a_br, a_mr, a_mw} !== 8'b0 || {a_mtor, a_urw} !== 2'b00) begin
      n_err++; $display("FAIL fl_zero: got ex/mem=%b wb=%b expected all 0",
                        {a_regds, a_alusrc, a_aop, a_br, a_mr, a_mw}, {a_mtor, a_urw});
    end
    n_chk++;
    if (a_cnt !== 16'd1) begin
      n_err++; $display("FAIL fl_cnt: got %0d expected 1", a_cnt);
    end
    #1;
    n_chk++;
    if (a_pcw !== 1'b1) begin
      n_err++; $display("FAIL fl_after: got pc_write=%b expected 1", a_pcw);
    end
    tick();
    n_chk++;
    if (a_regds !== 1'b1 || a_aop !== 3'd2) begin
      n_err++; $display("FAIL fl_refetch: got regds=%b aop=%0d expected 1 2", a_regds, a_aop);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(6'b111111, 5'd1, 5'd2, 1'b0); tick();
    n_chk++;
    if (a_ill !== 1'b1 || {a_regds, a_alusrc, a_aop} !== 5'b0) begin
      n_err++; $display("FAIL ill_set: got ill=%b ex=%b expected 1 00000",
                        a_ill, {a_regds, a_alusrc, a_aop});
    end
    drive(OP_R, 5'd1, 5'd2, 1'b0); tick();
    n_chk++;
    if ({a_br, a_bne, a_j, a_mr, a_mw} !== 5'b0) begin
      n_err++; $display("FAIL ill_mem: got %b expected 00000", {a_br, a_bne, a_j, a_mr, a_mw});
    end
    tick();
    n_chk++;
    if ({a_mtor, a_urw} !== 2'b00 || a_ill !== 1'b1) begin
      n_err++; $display("FAIL ill_wb: got wb=%b ill=%b expected 00 1", {a_mtor, a_urw}, a_ill);
    end
    tick();
    n_chk++;
    if (a_ill !== 1'b1) begin
      n_err++; $display("FAIL ill_sticky: got %b expected 1", a_ill);
    end
  endtask

  task automatic test_ext_ops();
    do_reset();
    drive(OP_BNE, 5'd1, 5'd2, 1'b0); tick();
    n_chk++;
    if (e_ill !== 1'b1 || a_ill !== 1'b0) begin
      n_err++; $display("FAIL ext_ill: got e=%b a=%b expected 1 0", e_ill, a_ill);
    end
    drive(OP_J, 5'd1, 5'd2, 1'b0); tick();
    n_chk++;
    if (a_bne !== 1'b1 || a_br !== 1'b1 || e_bne !== 1'b0) begin
      n_err++; $display("FAIL ext_bne: got a_bne=%b a_br=%b e_bne=%b expected 1 1 0",
                        a_bne, a_br, e_bne);
    end
    drive(OP_R, 5'd1, 5'd2, 1'b0); tick();
    n_chk++;
    if (a_j !== 1'b1 || e_j !== 1'b0 || a_ill !== 1'b0 || e_ill !== 1'b1) begin
      n_err++; $display("FAIL ext_j: got a_j=%b e_j=%b a_ill=%b e_ill=%b expected 1 0 0 1",
                        a_j, e_j, a_ill, e_ill);
    end
  endtask

  task automatic test_saturate();
    int exp_c;
    do_reset();
    drive(OP_LW, 5'd5, 5'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();  // LW enters ID/EX
      #1;
      n_chk++;
      if (a_pcw !== 1'b0) begin
        n_err++; $display("FAIL sat_stall[%0d]: got pc_write=%b expected 0", i, a_pcw);
      end
      tick();  // bubble
      exp_c = (i + 1 > 3) ? 3 : i + 1;
      n_chk++;
      if (c_cnt !== 2'(exp_c) || a_cnt !== 16'(i + 1)) begin
        n_err++; $display("FAIL sat_cnt[%0d]: got c=%0d a=%0d expected %0d %0d",
                          i, c_cnt, a_cnt, exp_c, i + 1);
      end
    end
    rst = 1'b1; tick();
    n_chk++;
    if (a_vec !== 16'h0 || a_cnt !== 16'd0 || c_cnt !== 2'd0 || a_pcw !== 1'b1) begin
      n_err++; $display("FAIL sat_rst: got vec=%h a=%0d c=%0d pcw=%b expected 0 0 0 1",
                        a_vec, a_cnt, c_cnt, a_pcw);
    end
    rst = 1'b0; tick();
    n_chk++;
    if (a_urw !== 1'b0) begin
      n_err++; $display("FAIL sat_nowb: got wb_urw=%b expected 0", a_urw);
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[12];
    pool[0] = OP_R;  pool[1] = OP_ADDI; pool[2] = 6'b001010; pool[3] = 6'b001100;
    pool[4] = OP_ORI; pool[5] = OP_LW;  pool[6] = OP_SW;     pool[7] = OP_BEQ;
    pool[8] = OP_BNE; pool[9] = OP_J;   pool[10] = OP_LW;    pool[11] = 6'b111111;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(pool[$urandom_range(0, (c % 100 == 99) ? 11 : 10)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0));
      #1;
      n_chk++;
      if (a_pcw !== !ref_stall() || a_ifw !== !ref_stall() || c_pcw !== a_pcw) begin
        n_err++; $display("FAIL rnd_pcw[%0d]: got %b/%b expected %b", c, a_pcw, a_ifw,
                          !ref_stall());
      end
      tick();
      n_chk++;
      if (a_vec !== m_vec || c_vec !== m_vec) begin
        n_err++; $display("FAIL rnd_vec[%0d]: got a=%h c=%h expected %h", c, a_vec, c_vec, m_vec);
      end
      n_chk++;
      if (a_cnt !== 16'(m_cnt) || c_cnt !== 2'((m_cnt > 3) ? 3 : m_cnt)) begin
        n_err++; $display("FAIL rnd_cnt[%0d]: got a=%0d c=%0d expected %0d", c, a_cnt, c_cnt,
                          m_cnt);
      end
      n_chk++;
      if (e_ill !== m_ill0 || e_bne !== 1'b0 || e_j !== 1'b0) begin
        n_err++; $display("FAIL rnd_e0[%0d]: got ill=%b bne=%b j=%b expected %b 0 0", c,
                          e_ill, e_bne, e_j, m_ill0);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq_flow();
    test_load_use();
    test_no_stall();
    test_flush();
    test_illegal();
    test_ext_ops();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_cunit.md
Name: pipe_cunit

Overview:
- Pipelined main control unit for the 5-stage MIPS datapath; replaces the single-cycle combinational decoder.
- Decodes the 6-bit opcode in ID and carries the EX, M and WB control bundles through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and drives stall/bubble insertion.
- Applies branch flush, flags illegal opcodes, and counts inserted bubbles.

Parameters:
- AOP_W, 3, ALU-op field width; values below are zero-extended to AOP_W.
- EXT_OPS, 1, 1 enables decode of BNE (000101) and J (000010); 0 treats them as illegal.
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- op_in  in  6  opcode of instruction in ID (instr[31:26])
- id_rs  in  REG_W  rs of ID instruction
- id_rt  in  REG_W  rt of ID instruction
- br_flush  in  1  branch resolved taken in MEM; kill younger instructions
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID register load enable
- ex_regds, ex_alusrc  out  1 each  EX bundle from ID/EX
- ex_aop  out  AOP_W  ALU op from ID/EX
- mem_branch, mem_bne, mem_jump, mem_mread, mem_mwrite  out  1 each  M bundle from EX/MEM
- wb_mtor, wb_urw  out  1 each  WB bundle from MEM/WB
- illegal  out  1  sticky illegal-opcode flag
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Decode is combinational in ID. Fields are RegDs, Branch, MRead, MtoR, AOp, MWrite, ALUsrc, Urw:
  - R-type 000000: 1,0,0,1,010,0,0,1
  - ADDI 001000: 0,0,0,1,011,0,1,1
  - SLTI 001010: 0,0,0,1,100,0,1,1
  - ANDI 001100: 0,0,0,1,101,0,1,1
  - ORI 001101: 0,0,0,1,110,0,1,1
  - LW 100011: 0,0,1,0,011,0,1,1
  - SW 101011: 0,0,0,0,011,1,1,0
  - BEQ 000100: 0,1,0,0,001,0,0,0
  - BNE (EXT_OPS=1): as BEQ plus bne=1
  - J (EXT_OPS=1): all zero except jump=1
- Don't-cares are resolved to 0. No X may propagate.
- Any other opcode decodes to an all-zero bundle (NOP) and sets illegal=1 on the next edge. The flag holds until rst.
- Pipeline registers:
  - ID/EX holds the EX, M and WB bundles plus the captured id_rt (ex_rt_q).
  - EX/MEM holds M and WB. MEM/WB holds WB.
  - Each stage output appears exactly 1 cycle after the prior stage. An ADDI in ID at edge N shows ex_* after N, mem_* after N+1, wb_* after N+2.
- Hazard:
  - stall = ID/EX.MRead & (ex_rt_q != 0) & ((ex_rt_q == id_rs) | (ex_rt_q == id_rt & op uses rt as source)).
  - "Uses rt as source" means R-type, SW, BEQ, BNE.
  - stall and pc_write/ifid_write are combinational: pc_write = ifid_write = ~stall.
- Stall: on the edge, ID/EX loads an all-zero bundle (bubble) and ex_rt_q loads 0. EX/MEM and MEM/WB advance normally. Stall lasts exactly 1 cycle per load-use pair.
- Flush: br_flush=1 zeros the bundles loaded into ID/EX and EX/MEM on that edge. MEM/WB advances normally, so the branch completes. stall is forced 0 and pc_write=1.
- Priority: rst > br_flush > stall > normal advance.
- bubble_cnt:
  - +1 per edge with stall; +1 per edge with br_flush (one flush event counts 1).
  - Saturates at 2^CNT_W-1; no wrap.
- Reset: all pipeline registers, ex_rt_q, illegal and bubble_cnt go to 0. While rst=1, pc_write=ifid_write=1.
- Reset mid-operation discards all in-flight bundles on that edge; no partial writeback is signalled (wb_urw=0 the cycle after).

Test Plan:
- rst, then ADDI, ORI, R-type, SW in consecutive cycles -> each bundle appears at ex_*, mem_*, wb_* 1/2/3 cycles later with the table values; pc_write constant 1, bubble_cnt=0.
- LW rt=5, then R-type rs=5 -> pc_write=ifid_write=0 for exactly 1 cycle; ex_* all zero the next cycle; R-type enters EX one cycle later; bubble_cnt=1.
- LW rt=0, then R-type rs=0 -> no stall; LW rt=7, then ADDI rt=7, rs=3 -> no stall (rt is a destination).
- BEQ in MEM with br_flush=1 while a load-use pair sits in ID/EX -> stall suppressed, pc_write=1; ID/EX and EX/MEM zeroed next cycle; BEQ's WB bundle still advances; bubble_cnt +1.
- op_in=111111 -> NOP bundle flows, illegal=1 and stays 1; with EXT_OPS=0, op_in=000101 -> illegal=1 and mem_bne stays 0.
- CNT_W=2, 5 consecutive stalls -> bubble_cnt 1,2,3,3,3; assert rst for 1 cycle mid-stream -> all outputs 0 next cycle, bubble_cnt=0.
